// File: rtl/wave_fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// wave_fetch_sequencer_pkg
//
// Purpose : Shared definitions for the waveform fetch sequencer.
//           - FSM state encoding of the fetch sequencer
//           - Waveform table (memory channel) select constants
//           - Default widths and table depth
//
// Ports   : none (package)
// -----------------------------------------------------------------------------
package wave_fetch_sequencer_pkg;

    // Default geometry of the waveform tables and the phase accumulator.
    localparam int unsigned SIZE_DEF    = 12;    // sample width in bits
    localparam int unsigned LOGSIZE_DEF = 10;    // table address width
    localparam int unsigned N_DEF       = 1024;  // table depth, 2**LOGSIZE_DEF
    localparam int unsigned ACC_W_DEF   = 24;    // phase accumulator width

    // Table select as seen on mem_channel.
    localparam logic CH_SINE = 1'b0;
    localparam logic CH_TRI  = 1'b1;

    // Fetch sequencer states.
    //   ST_IDLE  : waiting for an enabled tick
    //   ST_ISSUE : read strobe on the memory interface
    //   ST_WAIT  : memory returns the sample; captured on the way out
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_e;

endpackage : wave_fetch_sequencer_pkg

// File: rtl/wave_fetch_sequencer_phase_accumulator.sv
// -----------------------------------------------------------------------------
// wave_fetch_sequencer_phase_accumulator
//
// Purpose : Phase accumulator of the waveform generator. Holds the running
//           phase, advances it by the tuning word once per completed fetch,
//           and exposes the top logsize bits as the table index.
//
// Ports   :
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (phase -> 0)
//   clr_i      in   synchronous clear; wins over advance_i
//   advance_i  in   add tune_i to the phase on this edge
//   tune_i     in   phase increment, unsigned, ACC_W bits
//   addr_o     out  table index = acc[ACC_W-1 -: logsize]
// -----------------------------------------------------------------------------
module wave_fetch_sequencer_phase_accumulator
    import wave_fetch_sequencer_pkg::*;
#(
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned logsize = LOGSIZE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               advance_i,
    input  logic [ACC_W-1:0]   tune_i,
    output logic [logsize-1:0] addr_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // Clear has priority so a phase reset requested on the completion cycle
    // of a fetch is not lost to that fetch's accumulate. The add wraps
    // modulo 2**ACC_W by truncation, which also wraps the table index from
    // N-1 to 0 without any special case.
    always_comb begin
        // NOTE: assign a default before any branch so every path drives
        // acc_d; a missing default in always_comb infers a latch.
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (advance_i) begin
            acc_d = acc_q + tune_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments only, so every
        // register samples its inputs from before the edge.
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Integer part of the phase selects the table entry.
    assign addr_o = acc_q[ACC_W-1 -: logsize];

endmodule : wave_fetch_sequencer_phase_accumulator

// File: rtl/wave_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// wave_fetch_sequencer
//
// Purpose : Initiator side of the waveform-memory read interface. Each
//           enabled sample-rate tick fetches one sample from the selected
//           table at the current phase, registers it for the DAC path with
//           a one-cycle valid strobe, and then advances the phase.
//
//           Timing, tick sampled in cycle 0:
//             cycle 1 : ISSUE, mem_read high, address/channel stable
//             cycle 2 : WAIT, mem_sample valid, captured at end of cycle
//             cycle 3 : IDLE, dac_valid high; a new tick here is accepted
//
// Ports   :
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   1 = accept ticks; 0 = finish in-flight fetch, then idle
//   tick         in   one-cycle sample-rate strobe
//   wave_sel     in   table select for the next fetch (0 sine, 1 triangle)
//   tune         in   phase increment per sample, unsigned
//   phase_clr    in   synchronous clear of the phase accumulator
//   mem_read     out  read strobe to memory (high only in ISSUE)
//   mem_channel  out  table select to memory
//   mem_address  out  table address to memory
//   mem_sample   in   memory data, valid one cycle after mem_read
//   dac_data     out  last fetched sample
//   dac_valid    out  one-cycle pulse when dac_data updates
//   busy         out  high in ISSUE and WAIT
//   overrun      out  sticky: an enabled tick arrived while busy
// -----------------------------------------------------------------------------
module wave_fetch_sequencer
    import wave_fetch_sequencer_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned size    = SIZE_DEF,
    parameter int unsigned logsize = LOGSIZE_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               tick,
    input  logic               wave_sel,
    input  logic [ACC_W-1:0]   tune,
    input  logic               phase_clr,
    output logic               mem_read,
    output logic               mem_channel,
    output logic [logsize-1:0] mem_address,
    input  logic [size-1:0]    mem_sample,
    output logic [size-1:0]    dac_data,
    output logic               dac_valid,
    output logic               busy,
    output logic               overrun
);

    // The table index is a straight bit slice of the phase, which only
    // covers the whole table when the depth is an exact power of two.
    if (N != (32'd1 << logsize)) begin : g_bad_depth
        $error("wave_fetch_sequencer: N must equal 2**logsize");
    end

    if (ACC_W <= logsize) begin : g_bad_acc
        $error("wave_fetch_sequencer: ACC_W must exceed logsize");
    end

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    fetch_state_e       state_q,       state_d;
    logic [logsize-1:0] mem_address_q, mem_address_d;
    logic               mem_channel_q, mem_channel_d;
    logic [size-1:0]    dac_data_q,    dac_data_d;
    logic               dac_valid_q,   dac_valid_d;
    logic               overrun_q,     overrun_d;

    // Strobe to the accumulator: one accumulate per completed fetch.
    logic               acc_advance;
    logic [logsize-1:0] phase_addr;

    // An enabled tick; with enable low ticks are invisible, so they neither
    // start a fetch nor count as an overrun.
    logic               tick_en;
    assign tick_en = tick & enable;

    // -------------------------------------------------------------------------
    // Phase accumulator
    // -------------------------------------------------------------------------
    // tune is only looked at on the completion edge, so changes while busy
    // take effect for the accumulate of the fetch in flight and nothing
    // earlier. phase_clr does not touch mem_address_q, so a fetch already
    // in flight keeps its latched address.
    wave_fetch_sequencer_phase_accumulator #(
        .ACC_W   (ACC_W),
        .logsize (logsize)
    ) u_phase_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (phase_clr),
        .advance_i (acc_advance),
        .tune_i    (tune),
        .addr_o    (phase_addr)
    );

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        mem_address_d = mem_address_q;
        mem_channel_d = mem_channel_q;
        dac_data_d    = dac_data_q;
        dac_valid_d   = 1'b0;
        overrun_d     = overrun_q;
        acc_advance   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (tick_en) begin
                    // Address and channel are latched here and held through
                    // ISSUE and WAIT, so later wave_sel or phase changes do
                    // not disturb the fetch in flight.
                    state_d       = ST_ISSUE;
                    mem_address_d = phase_addr;
                    mem_channel_d = wave_sel;
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // Memory data is valid during this cycle only.
                state_d     = ST_IDLE;
                dac_data_d  = mem_sample;
                dac_valid_d = 1'b1;
                acc_advance = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A tick that cannot be served is dropped and remembered.
        if (tick_en && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mem_address_q <= '0;
            mem_channel_q <= CH_SINE;
            dac_data_q    <= '0;
            dac_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_address_q <= mem_address_d;
            mem_channel_q <= mem_channel_d;
            dac_data_q    <= dac_data_d;
            dac_valid_q   <= dac_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // mem_read and busy decode the state register directly, so an
    // asynchronous reset drops them in the same instant as the state.
    assign mem_read    = (state_q == ST_ISSUE);
    assign busy        = (state_q != ST_IDLE);
    assign mem_channel = mem_channel_q;
    assign mem_address = mem_address_q;
    assign dac_data    = dac_data_q;
    assign dac_valid   = dac_valid_q;
    assign overrun     = overrun_q;

endmodule : wave_fetch_sequencer

// File: doc/wave_fetch_sequencer.md
Name: wave_fetch_sequencer

Overview:
- Initiator side of the waveform-memory read interface: drives read, channel and address into main_memory and consumes the returned sample.
- A phase accumulator advances by a tuning word at each sample-rate tick. Each tick fetches one sample from the selected table (sine or triangle).
- The fetched sample is registered and presented to the DAC path with a one-cycle valid strobe.
- Sits between the tick/frequency control logic and main_memory / DAC driver.

Parameters:
- N, 1024, table depth in samples; must equal 2**logsize.
- size, 12, sample width in bits.
- logsize, 10, address width in bits.
- ACC_W, 24, phase accumulator width; ACC_W > logsize.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = accept ticks; 0 = finish any in-flight fetch, then stay idle.
- tick  in  1  one-cycle sample-rate strobe.
- wave_sel  in  1  0 = sine table, 1 = triangle table; drives mem_channel.
- tune  in  ACC_W  phase increment per sample, unsigned.
- phase_clr  in  1  synchronous clear of the accumulator.
- mem_read  out  1  read strobe to memory.
- mem_channel  out  1  table select to memory.
- mem_address  out  logsize  table address to memory.
- mem_sample  in  size  memory data, valid one cycle after mem_read.
- dac_data  out  size  last fetched sample.
- dac_valid  out  1  one-cycle pulse when dac_data updates.
- busy  out  1  high in ISSUE and WAIT.
- overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset (async, rst_n=0): state IDLE; acc=0; mem_read=0; mem_channel=0; mem_address=0; dac_data=0; dac_valid=0; busy=0; overrun=0.
  - Reset mid-fetch abandons the fetch; no dac_valid pulse is produced.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when tick=1 and enable=1. On that edge: mem_address <= acc[ACC_W-1 -: logsize]; mem_channel <= wave_sel.
  - ISSUE: mem_read=1 for exactly this cycle; address and channel held stable. Next state is WAIT.
  - WAIT: mem_sample is valid. On the WAIT->IDLE edge: dac_data <= mem_sample; dac_valid <= 1 for the following cycle; acc <= acc + tune (mod 2**ACC_W).
- Timing, with the tick sampled in cycle 0:
  - mem_read high in cycle 1.
  - dac_valid high in cycle 3.
  - Minimum tick spacing is 3 cycles; a tick in cycle 3 is accepted.
- mem_address and mem_channel hold their values between fetches. mem_read is 0 outside ISSUE.
- wave_sel and tune changes while busy have no effect until the next accepted tick. tune is sampled on the WAIT->IDLE edge.
- A tick while in ISSUE or WAIT is dropped and sets overrun. overrun clears only on reset.
- enable=0:
  - Ticks are ignored and do not set overrun.
  - An in-flight fetch completes normally, including its dac_valid pulse and acc update.
- phase_clr=1: acc <= 0 on the next edge.
  - It wins over a simultaneous WAIT->IDLE accumulate; the sample capture still happens.
  - It does not alter mem_address already latched for an in-flight fetch.
- Accumulator wrap is natural modular overflow; the address wraps from N-1 to 0 with no special case.
- dac_valid is a pure pulse and is never high on two consecutive cycles.

Decomposition:
- Shared package (e.g. wavegen_pkg):
  - FSM state encoding (IDLE, ISSUE, WAIT).
  - Channel select constants CH_SINE=0, CH_TRI=1.
  - Default widths: size, logsize, ACC_W.
- Natural sub-module: phase_accumulator (acc register, add, clear priority, address slice). The FSM and capture register stay in the top.

Test Plan:
- Reset then tune=16384 (one address step), wave_sel=0, tick every 4 cycles -> mem_address 0,1,2,3; mem_channel=0; each dac_data equals the sine table entry at that address; dac_valid exactly 3 cycles after each tick.
- tune=49152 (step 3), 342 ticks -> address sequence 0,3,...,1023, then 2 (wrap); no glitch on the wrap.
- Tick at cycle 0 and again at cycle 1 -> second tick dropped; overrun=1 and stays 1; exactly one dac_valid.
- Toggle wave_sel 0->1 in the cycle after a tick -> current fetch uses mem_channel=0 (sine); the next tick uses channel 1 and returns the triangle sample.
- phase_clr asserted in the same cycle as WAIT -> dac_data captured; next fetch address is 0.
- rst_n pulled low during ISSUE -> all outputs return to 0 immediately; no dac_valid; after release the first tick fetches address 0.
